// File: rtl/tester_pkg.sv
// Shared definitions for the tester stimulus path.
// Holds the sequencer state encoding, the per-pin force-format codes and
// default widths used by the vector sequencer and its prefetch buffer.
package tester_pkg;

  localparam int NUM_PINS_DEF = 8;
  localparam int CNT_W_DEF    = 10;
  localparam int IDX_W_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    RUN      = 2'd2,
    DONE     = 2'd3
  } state_e;

  // Plain-vector views of the state encoding for the state register.
  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_PREFETCH = PREFETCH;
  localparam logic [1:0] ST_RUN      = RUN;
  localparam logic [1:0] ST_DONE     = DONE;

  // Per-pin force-format codes carried alongside each drive value.
  localparam logic FF_R0     = 1'b0;
  localparam logic FF_DNRZ_L = 1'b1;

endpackage

// File: rtl/vector_skid_buf.sv
// One-entry holding buffer for the next {data, ff} vector.
// Ports: i_clk/i_rst_n (sync, active-low); i_fill loads i_data/i_ff;
// i_drain empties; i_flush empties and overrides a same-clock fill; o_valid/o_data/o_ff.
module vector_skid_buf #(
  parameter int NUM_PINS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_fill,
  input  logic                i_drain,
  input  logic                i_flush,
  input  logic [NUM_PINS-1:0] i_data,
  input  logic [NUM_PINS-1:0] i_ff,
  output logic                o_valid,
  output logic [NUM_PINS-1:0] o_data,
  output logic [NUM_PINS-1:0] o_ff
);

  logic                r_valid;
  logic [NUM_PINS-1:0] r_data;
  logic [NUM_PINS-1:0] r_ff;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ff    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_ff    <= i_ff;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ff    = r_ff;

endmodule

// File: rtl/test_vector_sequencer.sv
// Feeds one stimulus vector per test cycle (CYCLE_LENGTH clocks) to the pin drivers,
// prefetching one vector ahead over a valid/ready source and flagging underrun.
// Ports: run control (start/abort/length/count), vector source handshake,
// pin drive outputs (en/d/ff), cycle marker, vector index and status (busy/done/underrun).
module test_vector_sequencer
  import tester_pkg::*;
#(
  parameter int NUM_PINS = NUM_PINS_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int IDX_W    = IDX_W_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [CNT_W-1:0]    i_cycle_length,
  input  logic [IDX_W-1:0]    i_num_vectors,
  input  logic                i_vec_valid,
  input  logic [NUM_PINS-1:0] i_vec_data,
  input  logic [NUM_PINS-1:0] i_vec_ff,
  output logic                o_vec_ready,
  output logic                o_pin_en,
  output logic [NUM_PINS-1:0] o_pin_d,
  output logic [NUM_PINS-1:0] o_pin_ff,
  output logic                o_cycle_start,
  output logic [IDX_W-1:0]    o_vec_index,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_underrun
);

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_cl;
  logic [IDX_W-1:0]    r_n;
  logic [IDX_W-1:0]    r_fetched;
  logic [IDX_W-1:0]    r_vec_index;
  logic                r_pin_en;
  logic [NUM_PINS-1:0] r_pin_d;
  logic [NUM_PINS-1:0] r_pin_ff;
  logic                r_cycle_start;
  logic                r_done;
  logic                r_underrun;

  logic                w_busy;
  logic                w_buf_valid;
  logic [NUM_PINS-1:0] w_buf_data;
  logic [NUM_PINS-1:0] w_buf_ff;
  logic                w_vec_ready;
  logic                w_xfer;
  logic                w_start_ok;
  logic                w_abort;
  logic                w_boundary;
  logic                w_last;
  logic                w_drain;
  logic                w_fill;
  logic                w_flush;
  logic                w_degenerate;

  assign w_busy       = (r_state == ST_PREFETCH) || (r_state == ST_RUN);
  // Ready is a function of registered state only, never of i_vec_valid.
  assign w_vec_ready  = w_busy && !w_buf_valid && (r_fetched < r_n);
  assign w_xfer       = i_vec_valid && w_vec_ready;
  // ABORT wins over a simultaneous START.
  assign w_start_ok   = i_start && !i_abort && !w_busy;
  assign w_abort      = i_abort && w_busy;
  assign w_degenerate = (i_num_vectors == '0) || (i_cycle_length < CNT_W'(2));
  assign w_boundary   = (r_state == ST_RUN) && (r_count == r_cl);
  assign w_last       = (r_vec_index == (r_n - IDX_W'(1)));
  assign w_drain      = w_boundary && !w_last && w_buf_valid && !w_abort;
  // The first vector of a run bypasses the buffer and goes straight to the pins.
  assign w_fill       = w_xfer && (r_state == ST_RUN);
  // Any exit from RUN/PREFETCH leaves the buffer empty, including a vector
  // that happened to arrive on the underrun boundary clock.
  assign w_flush      = w_abort || (w_boundary && !w_drain);

  vector_skid_buf #(
    .NUM_PINS (NUM_PINS)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_fill  (w_fill),
    .i_drain (w_drain),
    .i_flush (w_flush),
    .i_data  (i_vec_data),
    .i_ff    (i_vec_ff),
    .o_valid (w_buf_valid),
    .o_data  (w_buf_data),
    .o_ff    (w_buf_ff)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_count       <= CNT_W'(1);
      r_cl          <= '0;
      r_n           <= '0;
      r_fetched     <= '0;
      r_vec_index   <= '0;
      r_pin_en      <= 1'b0;
      r_pin_d       <= '0;
      r_pin_ff      <= '0;
      r_cycle_start <= 1'b0;
      r_done        <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_cycle_start <= 1'b0;
      if (w_xfer) begin
        r_fetched <= r_fetched + IDX_W'(1);
      end
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) begin
            r_cl       <= i_cycle_length;
            r_n        <= i_num_vectors;
            r_fetched  <= '0;
            r_underrun <= 1'b0;
            if (w_degenerate) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_PREFETCH;
              r_done  <= 1'b0;
            end
          end
        end
        ST_PREFETCH: begin
          if (i_abort) begin
            r_state  <= ST_IDLE;
            r_pin_en <= 1'b0;
            r_pin_d  <= '0;
            r_pin_ff <= '0;
          end else if (w_xfer) begin
            r_state       <= ST_RUN;
            r_pin_d       <= i_vec_data;
            r_pin_ff      <= i_vec_ff;
            r_vec_index   <= '0;
            r_pin_en      <= 1'b1;
            r_cycle_start <= 1'b1;
            r_count       <= CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (i_abort) begin
            r_state  <= ST_IDLE;
            r_pin_en <= 1'b0;
            r_pin_d  <= '0;
            r_pin_ff <= '0;
          end else if (w_boundary) begin
            if (w_drain) begin
              r_pin_d       <= w_buf_data;
              r_pin_ff      <= w_buf_ff;
              r_vec_index   <= r_vec_index + IDX_W'(1);
              r_count       <= CNT_W'(1);
              r_cycle_start <= 1'b1;
            end else begin
              // Either the last vector finished or the source fell behind.
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_underrun <= r_underrun | !w_last;
              r_pin_en   <= 1'b0;
              r_pin_d    <= '0;
              r_pin_ff   <= '0;
            end
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_vec_ready   = w_vec_ready;
  assign o_pin_en      = r_pin_en;
  assign o_pin_d       = r_pin_d;
  assign o_pin_ff      = r_pin_ff;
  assign o_cycle_start = r_cycle_start;
  assign o_vec_index   = r_vec_index;
  assign o_busy        = w_busy;
  assign o_done        = r_done;
  assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_test_vector_sequencer.sv
// Directed bench for test_vector_sequencer with a cycle-level reference model.
// Inputs change #1/#2 after the rising edge; outputs are checked on the falling edge.
// The vector source is a table-driven process with an optional one-shot stall.
module tb_test_vector_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [9:0]  cl = '0;
  logic [15:0] nv = '0;
  logic        vv = 1'b0;
  logic [7:0]  vd = '0;
  logic [7:0]  vf = '0;

  logic        o_vec_ready, o_pin_en, o_cycle_start, o_busy, o_done, o_underrun;
  logic [7:0]  o_pin_d, o_pin_ff;
  logic [15:0] o_vec_index;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  test_vector_sequencer dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_abort        (abort),
    .i_cycle_length (cl),
    .i_num_vectors  (nv),
    .i_vec_valid    (vv),
    .i_vec_data     (vd),
    .i_vec_ff       (vf),
    .o_vec_ready    (o_vec_ready),
    .o_pin_en       (o_pin_en),
    .o_pin_d        (o_pin_d),
    .o_pin_ff       (o_pin_ff),
    .o_cycle_start  (o_cycle_start),
    .o_vec_index    (o_vec_index),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_underrun     (o_underrun)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- vector source ----------------
  logic [7:0] tab_d[16];
  logic [7:0] tab_f[16];
  int  run_id = 0, src_seen = 0, src_i = 0;
  int  stall_at = 99, stall_len = 0, stall_cnt = 0;
  bit  stall_used = 0;
  bit  src_en = 1;
  logic rdy_seen = 1'b0;

  always @(posedge clk) begin
    if (vv && rdy_seen) src_i++;
    #2;
    if (src_seen != run_id) begin
      src_seen = run_id; src_i = 0; stall_used = 0; stall_cnt = 0;
    end
    if (!stall_used && src_i == stall_at) begin
      stall_cnt = stall_len; stall_used = 1;
    end
    vv = src_en && (stall_cnt == 0) && (src_i < 16);
    if (stall_cnt > 0) stall_cnt--;
    vd = tab_d[src_i % 16];
    vf = tab_f[src_i % 16];
  end

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 prefetch, 2 run, 3 done. m_t = clocks elapsed in RUN.
  typedef struct packed { logic [7:0] d; logic [7:0] f; } vec_t;
  vec_t m_rx[$];
  int   m_mode = 0, m_cl = 0, m_n = 0, m_t = 0, m_idx = 0;
  logic m_en = 0, m_done = 0, m_under = 0;
  logic [7:0] m_pd = 0, m_pf = 0;
  bit   m_live = 0;

  // Ready whenever a fetch is still owed and nothing is queued beyond the shown vector.
  function automatic bit m_ready();
    if (m_mode == 1) return (m_rx.size() < m_n);
    if (m_mode == 2) return (m_rx.size() < m_n) && (m_rx.size() <= m_idx + 1);
    return 0;
  endfunction

  function automatic void m_stop(input int nxt);
    m_mode = nxt; m_en = 0; m_pd = 0; m_pf = 0;
  endfunction

  always @(posedge clk) begin
    bit xfer;
    int avail;
    xfer = vv && m_ready();
    if (!rst_n) begin
      m_mode = 0; m_en = 0; m_pd = 0; m_pf = 0; m_idx = 0;
      m_done = 0; m_under = 0; m_rx.delete(); m_live = 1;
    end else begin
      case (m_mode)
        0, 3: if (start && !abort) begin
          m_done = 0; m_under = 0; m_cl = int'(cl); m_n = int'(nv); m_rx.delete();
          if (nv == 0 || cl < 2) begin m_mode = 3; m_done = 1; end
          else m_mode = 1;
        end
        1: if (abort) m_stop(0);
           else if (xfer) begin
             m_rx.push_back({vd, vf});
             m_mode = 2; m_t = 0; m_idx = 0; m_pd = vd; m_pf = vf; m_en = 1;
           end
        default: if (abort) m_stop(0);
          else begin
            avail = m_rx.size();
            if (xfer) m_rx.push_back({vd, vf});
            if ((m_t % m_cl) == m_cl - 1) begin
              if (m_idx == m_n - 1) begin m_stop(3); m_done = 1; end
              else if (avail > m_idx + 1) begin
                m_idx++; m_pd = m_rx[m_idx].d; m_pf = m_rx[m_idx].f;
              end else begin m_stop(3); m_done = 1; m_under = 1; end
            end
            m_t++;
          end
      endcase
    end
  end

  always @(negedge clk) begin
    rdy_seen = o_vec_ready;
    if (m_live) begin
      chk("m_pin_en",   32'(o_pin_en),      32'(m_en));
      chk("m_pin_d",    32'(o_pin_d),       32'(m_pd));
      chk("m_pin_ff",   32'(o_pin_ff),      32'(m_pf));
      chk("m_cyc_start",32'(o_cycle_start), 32'(m_mode == 2 && (m_t % m_cl) == 0));
      chk("m_vec_index",32'(o_vec_index),   32'(m_idx));
      chk("m_busy",     32'(o_busy),        32'(m_mode == 1 || m_mode == 2));
      chk("m_done",     32'(o_done),        32'(m_done));
      chk("m_underrun", 32'(o_underrun),    32'(m_under));
      chk("m_vec_ready",32'(o_vec_ready),   32'(m_ready()));
    end
  end

  // ---------------- directed stimulus ----------------
  logic [7:0]  rec_d[64];
  logic [7:0]  rec_ff[64];
  logic        rec_en[64];
  logic        rec_cs[64];
  logic [15:0] rec_idx[64];
  bit          any_ready;

  task automatic pulse_start(input int c, input int n);
    @(posedge clk); #1;
    cl = 10'(c); nv = 16'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // k=1 is the first falling edge after the clock that sampled START.
  task automatic collect(input int k0, input int stop_k, output int kd);
    kd = 0;
    for (int k = k0; k < 64; k++) begin
      @(negedge clk);
      rec_d[k] = o_pin_d; rec_ff[k] = o_pin_ff; rec_en[k] = o_pin_en;
      rec_cs[k] = o_cycle_start; rec_idx[k] = o_vec_index;
      if (o_vec_ready) any_ready = 1;
      if (o_done) begin kd = k; break; end
      if (k == stop_k) break;
    end
    if (stop_k == 0) chk("done_reached", 32'(kd > 0), 1);
  endtask

  task automatic load_tab(input logic [7:0] d0, d1, d2, f0, f1, f2);
    for (int i = 0; i < 16; i++) begin
      tab_d[i] = 8'(8'h40 + i); tab_f[i] = 8'(i * 7);
    end
    tab_d[0] = d0; tab_d[1] = d1; tab_d[2] = d2;
    tab_f[0] = f0; tab_f[1] = f1; tab_f[2] = f2;
    run_id++;
  endtask

  initial begin
    int kd, en_cnt, cs_cnt;
    load_tab(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pin_en", 32'(o_pin_en), 0);
    chk("rst_pin_d", 32'(o_pin_d), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_ready", 32'(o_vec_ready), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic run: CL=4, N=3
    load_tab(8'hA5, 8'h3C, 8'hFF, 8'h01, 8'h02, 8'h03);
    pulse_start(4, 3);
    collect(1, 0, kd);
    chk("basic_done_k", 32'(kd), 14);
    en_cnt = 0; cs_cnt = 0;
    for (int k = 1; k <= kd; k++) begin
      if (rec_en[k]) en_cnt++;
      if (rec_cs[k]) cs_cnt++;
    end
    chk("basic_en_clocks", 32'(en_cnt), 12);
    chk("basic_cs_count", 32'(cs_cnt), 3);
    chk("basic_cs_k6", 32'(rec_cs[6]), 1);
    chk("basic_cs_k10", 32'(rec_cs[10]), 1);
    chk("basic_d_k2", 32'(rec_d[2]), 32'hA5);
    chk("basic_d_k5", 32'(rec_d[5]), 32'hA5);
    chk("basic_d_k6", 32'(rec_d[6]), 32'h3C);
    chk("basic_d_k13", 32'(rec_d[13]), 32'hFF);
    chk("basic_end_d", 32'(rec_d[kd]), 0);

    // Backpressure: source stalls 5 clocks on the second vector
    load_tab(8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00);
    stall_at = 1; stall_len = 5;
    pulse_start(4, 3);
    collect(1, 0, kd);
    chk("under_done_k", 32'(kd), 6);
    chk("under_flag", 32'(o_underrun), 1);
    chk("under_pin_en", 32'(o_pin_en), 0);
    chk("under_index", 32'(o_vec_index), 0);
    stall_at = 99;

    // ABORT at count 2 of vector 1, then a clean 5-vector rerun
    load_tab(8'h51, 8'h52, 8'h53, 8'h00, 8'h00, 8'h00);
    pulse_start(4, 5);
    collect(1, 7, kd);
    chk("abort_vec1_cs", 32'(rec_cs[6]), 1);
    chk("abort_vec1_idx", 32'(rec_idx[7]), 1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(o_busy), 0);
    chk("abort_pin_en", 32'(o_pin_en), 0);
    chk("abort_ready", 32'(o_vec_ready), 0);
    chk("abort_done", 32'(o_done), 0);
    load_tab(8'h61, 8'h62, 8'h63, 8'h00, 8'h00, 8'h00);
    pulse_start(4, 5);
    collect(1, 0, kd);
    chk("rerun_done_k", 32'(kd), 22);
    chk("rerun_d_k2", 32'(rec_d[2]), 32'h61);
    chk("rerun_idx_k21", 32'(rec_idx[21]), 4);
    chk("rerun_underrun", 32'(o_underrun), 0);

    // Degenerate starts
    any_ready = 0;
    pulse_start(4, 0);
    collect(1, 0, kd);
    chk("n0_done_k", 32'(kd), 1);
    pulse_start(1, 3);
    collect(1, 0, kd);
    chk("cl1_done_k", 32'(kd), 1);
    chk("deg_no_ready", 32'(any_ready), 0);

    // CL=2, N=2 with complementary formats
    load_tab(8'h12, 8'h34, 8'h00, 8'h0F, 8'hF0, 8'h00);
    pulse_start(2, 2);
    collect(1, 0, kd);
    chk("cl2_done_k", 32'(kd), 6);
    chk("cl2_ff_k2", 32'(rec_ff[2]), 32'h0F);
    chk("cl2_ff_k3", 32'(rec_ff[3]), 32'h0F);
    chk("cl2_ff_k4", 32'(rec_ff[4]), 32'hF0);
    chk("cl2_ff_k5", 32'(rec_ff[5]), 32'hF0);
    chk("cl2_d_k4", 32'(rec_d[4]), 32'h34);

    // Reset mid-run at count 3
    load_tab(8'h71, 8'h72, 8'h73, 8'h00, 8'h00, 8'h00);
    pulse_start(4, 3);
    collect(1, 4, kd);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_pin_en", 32'(o_pin_en), 0);
    chk("mrst_pin_d", 32'(o_pin_d), 0);
    chk("mrst_pin_ff", 32'(o_pin_ff), 0);
    chk("mrst_index", 32'(o_vec_index), 0);
    chk("mrst_busy", 32'(o_busy), 0);
    load_tab(8'h81, 8'h82, 8'h83, 8'h00, 8'h00, 8'h00);
    pulse_start(4, 3);
    collect(1, 0, kd);
    chk("mrst_rerun_k", 32'(kd), 14);
    chk("mrst_rerun_d", 32'(rec_d[2]), 32'h81);
    chk("mrst_rerun_idx", 32'(rec_idx[2]), 0);

    // START during RUN is ignored; START+ABORT together aborts
    load_tab(8'h91, 8'h92, 8'h93, 8'h00, 8'h00, 8'h00);
    pulse_start(4, 2);
    collect(1, 3, kd);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    collect(4, 0, kd);
    chk("busy_start_k", 32'(kd), 10);
    load_tab(8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'h00);
    pulse_start(4, 2);
    collect(1, 3, kd);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 begin start = 1'b0; abort = 1'b0; end
    @(negedge clk);
    chk("sa_busy", 32'(o_busy), 0);
    chk("sa_pin_en", 32'(o_pin_en), 0);
    chk("sa_done", 32'(o_done), 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
